// File: rtl/xor_descrambler_if.sv
// Word-stream bundle for xor_descrambler.
//   seed_valid/seed        : LFSR seed load strobe and value (source -> block)
//   in_valid/in_ready/in_data    : scrambled word handshake (source -> block)
//   out_valid/out_ready/out_data : descrambled word handshake (block -> sink)
//   seeded/word_count      : status (block -> observer)
// slave = the descrambler; master = the environment driving it.
interface xor_descrambler_if #(parameter int WIDTH = 32);
  logic             seed_valid;
  logic [WIDTH-1:0] seed;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             seeded;
  logic [15:0]      word_count;

  modport master (
    output seed_valid, seed, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, seeded, word_count
  );

  modport slave (
    input  seed_valid, seed, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, seeded, word_count
  );
endinterface

// File: rtl/xor_descrambler.sv
// Additive stream descrambler. Each accepted word is XORed with the current
// Galois-LFSR keystream word, which then advances one step. Output is a single
// register stage that can drain and refill in the same cycle.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : xor_descrambler_if.slave (seed load, input/output handshakes, status)
module xor_descrambler #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7
) (
  input logic               clk,
  input logic               rst_n,
  xor_descrambler_if.slave  bus
);

  typedef enum logic {UNSEEDED = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] key;
  logic [WIDTH-1:0] key_step;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [15:0]      word_count_q;
  logic             seeded;
  logic             in_ready;
  logic             accept;

  // FSM: only leaves UNSEEDED on a seed load; reset is the only way back.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= UNSEEDED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == UNSEEDED && bus.seed_valid) state_nxt = RUN;
  end

  assign seeded   = (state == RUN);
  // Output register is free if empty or being drained this cycle.
  assign in_ready = seeded && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign key_step = {key[WIDTH-2:0], 1'b0} ^ (key[WIDTH-1] ? POLY : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key          <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      if (accept) begin
        // Uses the key as it was before this edge, even if a seed lands now.
        out_data_q  <= bus.in_data ^ key;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A seed load wins over the advance/increment of a simultaneous accept.
      if (bus.seed_valid) begin
        key          <= (bus.seed == '0) ? WIDTH'(1) : bus.seed;
        word_count_q <= '0;
      end else if (accept) begin
        key          <= key_step;
        word_count_q <= word_count_q + 16'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.seeded     = seeded;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_xor_descrambler.sv
module tb_xor_descrambler;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xor_descrambler_if #(.WIDTH(32)) bus ();
  xor_descrambler #(.WIDTH(32), .POLY(POLY)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Keystream generator of the sending side.
  function automatic logic [31:0] lfsr_next(input logic [31:0] k);
    return (k << 1) ^ ((k >> 31) != 0 ? POLY : 32'h0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mk;
  logic [31:0] held;

  initial begin
    bus.seed_valid = 0; bus.seed = 0; bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;

    // Reset, then input offered with no seed.
    step(); step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_seeded", 32'(bus.seeded), 0);
    chk("rst_wc", 32'(bus.word_count), 0);
    rst_n = 1;
    bus.in_valid = 1; bus.in_data = 32'hDEADBEEF; bus.out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("noseed_in_ready", 32'(bus.in_ready), 0);
      step();
      chk("noseed_out_valid", 32'(bus.out_valid), 0);
      chk("noseed_seeded", 32'(bus.seeded), 0);
      chk("noseed_wc", 32'(bus.word_count), 0);
    end

    // Seed 1, stream 33 all-ones words.
    bus.in_valid = 0; bus.seed_valid = 1; bus.seed = 32'h1;
    step();
    bus.seed_valid = 0;
    chk("seed_seeded", 32'(bus.seeded), 1);
    mk = 32'h1;
    bus.in_valid = 1; bus.in_data = 32'hFFFFFFFF;
    for (int i = 1; i <= 33; i++) begin
      step();
      chk("stream_word", bus.out_data, 32'hFFFFFFFF ^ mk);
      if (i == 1)  chk("stream_w1", bus.out_data, 32'hFFFFFFFE);
      if (i == 2)  chk("stream_w2", bus.out_data, 32'hFFFFFFFD);
      if (i == 3)  chk("stream_w3", bus.out_data, 32'hFFFFFFFB);
      if (i == 32) chk("stream_w32", bus.out_data, 32'h7FFFFFFF);
      if (i == 33) chk("stream_w33", bus.out_data, 32'hFB3EE248);
      mk = lfsr_next(mk);
    end
    bus.in_valid = 0;
    step();
    chk("stream_wc", 32'(bus.word_count), 33);
    chk("stream_drained", 32'(bus.out_valid), 0);

    // Backpressure.
    bus.seed_valid = 1; bus.seed = 32'h1;
    step();
    bus.seed_valid = 0;
    bus.in_valid = 1; bus.in_data = 32'h12345678; bus.out_ready = 0;
    step();
    bus.in_data = 32'hAAAAAAAA;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_data", bus.out_data, 32'h12345679);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_wc", 32'(bus.word_count), 1);
      step();
    end
    bus.out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    step();
    chk("bp_next_word", bus.out_data, 32'hAAAAAAAA ^ 32'h2);
    chk("bp_next_wc", 32'(bus.word_count), 2);
    bus.in_valid = 0;
    step();

    // Zero seed behaves as seed 1.
    bus.seed_valid = 1; bus.seed = 32'h0;
    step();
    bus.seed_valid = 0;
    bus.in_valid = 1; bus.in_data = 32'h0;
    step();
    chk("seed0_word", bus.out_data, 32'h00000001);
    mk = 32'h2;
    bus.in_valid = 0;
    step();

    // Seed and accept in the same cycle.
    bus.in_valid = 1; bus.in_data = 32'h0F0F0F0F;
    bus.seed_valid = 1; bus.seed = 32'hA5A5A5A5;
    step();
    chk("seedacc_word", bus.out_data, 32'h0F0F0F0F ^ mk);
    chk("seedacc_wc", 32'(bus.word_count), 0);
    bus.seed_valid = 0; bus.in_data = 32'h11111111;
    step();
    chk("seedacc_next", bus.out_data, 32'h11111111 ^ 32'hA5A5A5A5);
    chk("seedacc_next_wc", 32'(bus.word_count), 1);
    held = 32'h11111111 ^ 32'hA5A5A5A5;

    // Seed while output stalled: held word unaffected, new key used after.
    bus.in_valid = 0; bus.out_ready = 0; bus.seed_valid = 1; bus.seed = 32'h3;
    step();
    bus.seed_valid = 0;
    chk("stallseed_data", bus.out_data, held);
    chk("stallseed_valid", 32'(bus.out_valid), 1);
    bus.out_ready = 1;
    step();
    chk("stallseed_drain", 32'(bus.out_valid), 0);
    bus.in_valid = 1; bus.in_data = 32'h0;
    step();
    chk("stallseed_key", bus.out_data, 32'h3);
    bus.in_valid = 0;
    step();

    // Reset mid-stream discards held word and seed.
    bus.in_valid = 1; bus.in_data = 32'h5; bus.out_ready = 0;
    step();
    rst_n = 0; bus.in_valid = 0;
    step();
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_seeded", 32'(bus.seeded), 0);
    rst_n = 1; bus.out_ready = 1;
    step();
    bus.in_valid = 1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 0;
    step();

    // Loopback against a scrambler model with random valid/ready.
    begin
      logic [31:0] sd, sk, p, c;
      logic [31:0] rq[$];
      int sent, rcvd, cyc;
      bit pending, acc, take;
      sd = $urandom;
      sk = (sd == 0) ? 32'h1 : sd;
      bus.seed_valid = 1; bus.seed = sd;
      step();
      bus.seed_valid = 0;
      sent = 0; rcvd = 0; cyc = 0; pending = 0; p = 0; c = 0;
      while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
        if (!pending && sent < 1000 && ($urandom % 4) != 0) begin
          p = $urandom; c = p ^ sk; pending = 1;
        end
        bus.in_valid = pending;
        bus.in_data = pending ? c : $urandom;
        bus.out_ready = ($urandom % 3) != 0;
        #1;
        acc  = bus.in_valid && bus.in_ready;
        take = bus.out_valid && bus.out_ready;
        if (take) begin
          if (rq.size() == 0) chk("lb_extra_word", bus.out_data, 32'hXXXXXXXX);
          else chk("lb_word", bus.out_data, rq.pop_front());
          rcvd++;
        end
        if (acc) begin
          rq.push_back(p);
          sk = lfsr_next(sk);
          pending = 0;
          sent++;
        end
        step();
        cyc++;
      end
      chk("lb_timeout", 32'(cyc < 20000), 1);
      chk("lb_rcvd", 32'(rcvd), 1000);
      chk("lb_leftover", 32'(rq.size()), 0);
      chk("lb_wc", 32'(bus.word_count), 1000);
    end

    bus.in_valid = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/xor_descrambler.md
# xor_descrambler

Additive stream descrambler: the receive-side counterpart of the ALU's XOR datapath. It recovers plaintext words by XORing each incoming 32-bit word with a keystream word. The keystream comes from an LFSR seeded identically to the sender's. It sits between a word-stream source and sink, with valid/ready handshakes on both sides and a registered output stage.

## Interface
- WIDTH, 32, data and LFSR width
- POLY, 32'h04C11DB7, Galois LFSR feedback polynomial (taps XORed in when MSB shifts out)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low (one clock; sampled on clk rising edge)
- seed_valid  input  1  load seed this cycle
- seed  input  WIDTH  LFSR seed value
- in_valid  input  1  input word present
- in_ready  output  1  block can accept input this cycle
- in_data  input  WIDTH  scrambled word
- out_valid  output  1  output register holds a descrambled word
- out_ready  input  1  sink accepts output this cycle
- out_data  output  WIDTH  descrambled word (registered)
- seeded  output  1  LFSR has been loaded since reset
- word_count  output  16  words accepted since last seed load, wraps 0xFFFF -> 0x0000

## Operation
- State machine: UNSEEDED (after reset) -> RUN on seed_valid; RUN stays RUN. Reset returns to UNSEEDED from any state.
- Seed load: key <= (seed == 0) ? 1 : seed (zero seed would lock up the LFSR); word_count <= 0; seeded <= 1.
- Accept: in_valid && in_ready. out_data <= in_data ^ key; out_valid <= 1; key advances one Galois step: key <= {key[30:0],1'b0} ^ (key[31] ? POLY : 0); word_count <= word_count + 1.
- in_ready = seeded && (!out_valid || out_ready). The output register refills in the same cycle it drains (full throughput, 1 word/cycle).
- Drain: out_valid && out_ready && no accept -> out_valid <= 0.
- Stall: out_valid && !out_ready -> out_data, out_valid, key and word_count hold. The sink sees stable data until it is taken.
- Seed and accept in the same cycle: the accepted word uses the OLD key. After the edge, key = seed (the seed overrides the advance) and word_count = 0 (the seed overrides the increment).
- Seed while the output is stalled: the held output is unaffected.
- in_data is ignored when in_valid is low. out_data is don't-care-stable (holds its last value) when out_valid is low.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, seeded 0, word_count 0, key 0 (not observable).
- Latency: input accepted at edge N -> out_valid high and out_data valid from edge N (visible in cycle N+1).
- in_ready is combinational from out_ready, out_valid and seeded. There are no other combinational in-to-out paths.
- Reset mid-stream discards the held output word and the key. seed_valid is required again before any input is accepted.
- word_count wrap: 0xFFFF + 1 -> 0x0000, with no flag.

## Test plan
- Reset then no seed: hold in_valid=1 for 10 cycles -> in_ready=0, out_valid=0, seeded=0, word_count=0 throughout.
- seed=0x00000001, then stream in_data=0xFFFFFFFF for 33 words with out_ready=1 -> out_data = 0xFFFFFFFE, 0xFFFFFFFD, 0xFFFFFFFB, … The 32nd word = 0x7FFFFFFF (key 0x80000000). The 33rd word = 0xFB3EE248 (key 0x04C11DB7). word_count=33.
- Backpressure: after the seed, push 0x12345678 with out_ready=0 for 5 cycles -> out_data=0x12345679 held, in_ready=0, word_count=1. Raise out_ready -> the next word is accepted in that same cycle.
- seed=0x00000000 -> behaves as seed 1. First in_data 0x0 -> out_data 0x00000001.
- Seed and accept in the same cycle (current key K, new seed 0xA5A5A5A5) -> that output = in_data ^ K. The next accepted word is XORed with 0xA5A5A5A5. word_count reads 1 after the next accept.
- Loopback: a scrambler model with the same seed, fed 1000 random words with random valid/ready -> every out_data equals the original plaintext, in order, with no drops or duplicates.
